tow_game_ctrl: RTL and testbench
================================

# tow_game_ctrl

Tug-of-war game controller. Turns the two player buttons and the start button into game state, and drives the LED multiplexer's `led_control` select and its 8-bit `score` input. It sits directly upstream of the LED mux. It owns the state machine, the countdown, the rope position and the win blinking.

## Interface
Parameters:
- `COUNT_CYCLES`, default 50_000_000: countdown length in clocks (1 s at 50 MHz); must be ≥ 2.
- `BLINK_CYCLES`, default 12_500_000: half-period of the win blink in clocks; must be ≥ 1.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `btn_start`  in  1: start button level, already synchronized and debounced.
- `btn_l`  in  1: left player button level, already synchronized and debounced.
- `btn_r`  in  1: right player button level, already synchronized and debounced.
- `led_control`  out  2: mux select. 0 = off, 1 = all on, 2 = score, 3 = fixed pattern.
- `score`  out  8: rope display for the mux.
- `win_l`  out  1: high while in WIN with the left player as winner.
- `win_r`  out  1: high while in WIN with the right player as winner.

## Operation
- Each button goes through a rising-edge detector. The previous-sample register resets to 1, so a button held through reset never fires. An edge is `btn & ~prev`.
- Rope position `pos` is 3 bits, range 0..6, centre 3. `score = 8'b11 << pos` while in PLAY.
- **IDLE**
  - Outputs: `led_control=0`, `score=0`.
  - Start edge → COUNTDOWN.
- **COUNTDOWN**
  - Outputs: `led_control=1`, `score=8'b0001_1000`, `pos` held at 3, timer cleared on entry.
  - Leaves for PLAY when the timer reaches `COUNT_CYCLES-1`.
  - Player edges are ignored, unless the configuration macro below is defined.
- **PLAY**
  - Outputs: `led_control=2`.
  - `btn_l` edge alone: `pos+1`.
  - `btn_r` edge alone: `pos-1`.
  - Both edges in the same cycle: no move.
  - `btn_l` edge at `pos==6` → WIN, winner left, `pos` unchanged.
  - `btn_r` edge at `pos==0` → WIN, winner right.
  - Start edges are ignored.
- **WIN**
  - Blink phase toggles every `BLINK_CYCLES`, beginning in phase A on entry.
  - Phase A: `led_control=3`.
  - Phase B: `led_control=2`, with `score=8'hF0` (left winner) or `8'h0F` (right winner).
  - `win_l` or `win_r` is high for the whole state.
  - Start edge → COUNTDOWN (rematch), with `pos` reset to 3 and the win flags cleared.
- The timer is a single counter of `$clog2(max(COUNT_CYCLES,BLINK_CYCLES))` bits. It is shared by COUNTDOWN and WIN and cleared on every state change.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `pos=3`, timer 0, blink phase A, `led_control=0`, `score=0`, `win_l=0`, `win_r=0`.
- Edge latency:
  - A button first sampled high at clock edge N has its effect visible on the outputs after edge N.
  - A held button produces exactly one edge.
  - A release followed by a re-press is required to produce another edge.
- COUNTDOWN length: if the start edge is sampled at edge N, `led_control` is 1 from N through N+`COUNT_CYCLES`-1 and becomes 2 after edge N+`COUNT_CYCLES`.
- `rst_n` low at any clock edge, in any state mid-game, forces all reset values after that edge. It takes priority over every transition.

## Configuration
- Macro: `TOW_FALSE_START_EN`.
- Defined: a player edge during COUNTDOWN goes straight to WIN with the opponent as winner.
  - Simultaneous false starts: no winner, return to IDLE.
- Undefined: player edges during COUNTDOWN are ignored.

## Structure
- Package `tow_pkg` holds:
  - the state enum: IDLE, COUNTDOWN, PLAY, WIN;
  - the `led_control` encodings: LED_OFF=0, LED_ALL=1, LED_SCORE=2, LED_PATTERN=3;
  - the constants POS_CENTER=3 and POS_MAX=6;
  - the win masks 8'hF0 and 8'h0F.
- Sub-module `tow_edge_detect`: a one-bit rising-edge detector, instantiated three times.

## Test plan
- Reset with `btn_l` held high, then release `rst_n` → no movement; outputs stay 0/0 in IDLE.
- Start pulse with `COUNT_CYCLES=4` → `led_control=1` for exactly 4 cycles, then 2 with `score=8'h18`.
- In PLAY, give `btn_l` 3 separate presses → `score` steps 8'h30, 8'h60, 8'hC0. A 4th press → WIN with `win_l=1`, and `led_control` alternates 3/2 (`score=8'hF0`) every `BLINK_CYCLES`.
- In PLAY at `pos=3`, press `btn_l` and `btn_r` on the same cycle → `score` stays 8'h18.
- With `TOW_FALSE_START_EN` defined, press `btn_r` during COUNTDOWN → WIN, `win_l=1`. With the macro undefined, the same stimulus → countdown completes normally.
- Assert `rst_n` low mid-PLAY at `pos=5` → IDLE, `score=0`, `led_control=0`, and `pos` returns to 3 on the next game.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game controller.
package tow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNTDOWN,
        ST_PLAY,
        ST_WIN
    } state_t;

    localparam logic [1:0] LED_OFF     = 2'd0;
    localparam logic [1:0] LED_ALL     = 2'd1;
    localparam logic [1:0] LED_SCORE   = 2'd2;
    localparam logic [1:0] LED_PATTERN = 2'd3;

    localparam logic [2:0] POS_CENTER = 3'd3;
    localparam logic [2:0] POS_MAX    = 3'd6;

    localparam logic [7:0] WIN_MASK_L   = 8'hF0;
    localparam logic [7:0] WIN_MASK_R   = 8'h0F;
    localparam logic [7:0] SCORE_CENTER = 8'h18;

    function automatic logic [7:0] rope_score(input logic [2:0] pos);
        logic [7:0] w_pair;
        w_pair = 8'h03;
        return w_pair << pos;
    endfunction

endpackage

// File: rtl/tow_edge_detect.sv
// One-bit rising-edge detector; the history bit resets high so a
// button held through reset never fires.
module tow_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_edge = i_btn & ~r_prev;

endmodule

// File: rtl/tow_game_ctrl.sv
// Tug-of-war game controller: FSM, countdown, rope position, win blink.
// Optional TOW_FALSE_START_EN: player edge in countdown awards the opponent.
module tow_game_ctrl
    import tow_pkg::*;
#(
    parameter int COUNT_CYCLES = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] led_control,
    output logic [7:0] score,
    output logic       win_l,
    output logic       win_r
);

    localparam int MAX_CYC = (COUNT_CYCLES > BLINK_CYCLES) ?
                             COUNT_CYCLES : BLINK_CYCLES;
    localparam int TW = $clog2(MAX_CYC);
    localparam logic [TW-1:0] CNT_LAST = TW'(COUNT_CYCLES - 1);
    localparam logic [TW-1:0] BLK_LAST = TW'(BLINK_CYCLES - 1);

    logic w_start;
    logic w_l;
    logic w_r;

    tow_edge_detect u_ed_start (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_start),
        .o_edge  (w_start)
    );

    tow_edge_detect u_ed_l (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_l),
        .o_edge  (w_l)
    );

    tow_edge_detect u_ed_r (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_r),
        .o_edge  (w_r)
    );

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_pos;
    logic [2:0]      w_pos_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_phase_b;
    logic            w_phase_nxt;
    logic            r_left;
    logic            w_left_nxt;
    logic [1:0]      w_led_nxt;
    logic [7:0]      w_score_nxt;
    logic            w_win_l_nxt;
    logic            w_win_r_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pos       <= POS_CENTER;
            r_timer     <= '0;
            r_phase_b   <= 1'b0;
            r_left      <= 1'b0;
            led_control <= LED_OFF;
            score       <= 8'h00;
            win_l       <= 1'b0;
            win_r       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_timer     <= w_timer_nxt;
            r_phase_b   <= w_phase_nxt;
            r_left      <= w_left_nxt;
            led_control <= w_led_nxt;
            score       <= w_score_nxt;
            win_l       <= w_win_l_nxt;
            win_r       <= w_win_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_timer_nxt = r_timer;
        w_phase_nxt = r_phase_b;
        w_left_nxt  = r_left;

        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                w_timer_nxt = r_timer + 1'b1;
`ifdef TOW_FALSE_START_EN
                if (w_l && w_r) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_l) begin
                    w_state_nxt = ST_WIN;
                    w_left_nxt  = 1'b0;
                end else if (w_r) begin
                    w_state_nxt = ST_WIN;
                    w_left_nxt  = 1'b1;
                end else if (r_timer == CNT_LAST) begin
                    w_state_nxt = ST_PLAY;
                end
`else
                if (r_timer == CNT_LAST) w_state_nxt = ST_PLAY;
`endif
            end
            ST_PLAY: begin
                if (w_l && !w_r) begin
                    if (r_pos == POS_MAX) begin
                        w_state_nxt = ST_WIN;
                        w_left_nxt  = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + 3'd1;
                    end
                end else if (w_r && !w_l) begin
                    if (r_pos == 3'd0) begin
                        w_state_nxt = ST_WIN;
                        w_left_nxt  = 1'b0;
                    end else begin
                        w_pos_nxt = r_pos - 3'd1;
                    end
                end
            end
            ST_WIN: begin
                if (w_start) begin
                    w_state_nxt = ST_COUNTDOWN;
                end else if (r_timer == BLK_LAST) begin
                    w_timer_nxt = '0;
                    w_phase_nxt = ~r_phase_b;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Every state change restarts the shared timer and blink phase.
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
            w_phase_nxt = 1'b0;
        end
        if (w_state_nxt == ST_COUNTDOWN) w_pos_nxt = POS_CENTER;
    end

    always_comb begin
        w_led_nxt   = LED_OFF;
        w_score_nxt = 8'h00;
        w_win_l_nxt = 1'b0;
        w_win_r_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_IDLE: begin
                w_led_nxt = LED_OFF;
            end
            ST_COUNTDOWN: begin
                w_led_nxt   = LED_ALL;
                w_score_nxt = SCORE_CENTER;
            end
            ST_PLAY: begin
                w_led_nxt   = LED_SCORE;
                w_score_nxt = rope_score(w_pos_nxt);
            end
            ST_WIN: begin
                w_led_nxt   = w_phase_nxt ? LED_SCORE : LED_PATTERN;
                w_score_nxt = w_left_nxt ? WIN_MASK_L : WIN_MASK_R;
                w_win_l_nxt = w_left_nxt;
                w_win_r_nxt = ~w_left_nxt;
            end
            default: w_led_nxt = LED_OFF;
        endcase
    end

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Self-checking bench for tow_game_ctrl with a game-level reference model.
module tb_tow_game_ctrl;

    localparam int CNT = 4;
    localparam int BLK = 3;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       btn_l;
    logic       btn_r;
    logic [1:0] led_control;
    logic [7:0] score;
    logic       win_l;
    logic       win_r;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 countdown, 2 play, 3 win.
    int m_mode;
    int m_cnt;
    int m_pos;
    bit m_left;
    bit m_ps, m_pl, m_pr;

    tow_game_ctrl #(
        .COUNT_CYCLES (CNT),
        .BLINK_CYCLES (BLK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .led_control (led_control),
        .score       (score),
        .win_l       (win_l),
        .win_r       (win_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clock(input bit rn, input bit s, input bit l,
                               input bit r);
        bit es, el, er;
        if (!rn) begin
            m_mode = 0; m_cnt = 0; m_pos = 3; m_left = 0;
            m_ps = 1; m_pl = 1; m_pr = 1;
            return;
        end
        es = s && !m_ps; el = l && !m_pl; er = r && !m_pr;
        m_ps = s; m_pl = l; m_pr = r;
        case (m_mode)
            0: if (es) begin m_mode = 1; m_cnt = 0; m_pos = 3; end
            1: begin
`ifdef TOW_FALSE_START_EN
                if (el && er) begin
                    m_mode = 0; m_cnt = 0;
                end else if (el || er) begin
                    m_mode = 3; m_cnt = 0; m_left = er;
                end else begin
                    m_cnt++;
                    if (m_cnt == CNT) begin m_mode = 2; m_cnt = 0; end
                end
`else
                m_cnt++;
                if (m_cnt == CNT) begin m_mode = 2; m_cnt = 0; end
`endif
            end
            2: begin
                if (el && !er) begin
                    if (m_pos == 6) begin m_mode = 3; m_cnt = 0; m_left = 1; end
                    else m_pos++;
                end else if (er && !el) begin
                    if (m_pos == 0) begin m_mode = 3; m_cnt = 0; m_left = 0; end
                    else m_pos--;
                end
            end
            default: begin
                if (es) begin m_mode = 1; m_cnt = 0; m_pos = 3; end
                else m_cnt++;
            end
        endcase
    endtask

    function automatic logic [11:0] exp_vec();
        logic [1:0] led;
        logic [7:0] sc;
        logic wl, wr;
        led = 2'd0; sc = 8'h00; wl = 1'b0; wr = 1'b0;
        case (m_mode)
            1: begin led = 2'd1; sc = 8'h18; end
            2: begin led = 2'd2; sc = 8'((3 * (1 << m_pos)) & 255); end
            3: begin
                led = (((m_cnt / BLK) % 2) == 1) ? 2'd2 : 2'd3;
                sc  = m_left ? 8'hF0 : 8'h0F;
                wl  = m_left;
                wr  = !m_left;
            end
            default: begin led = 2'd0; sc = 8'h00; end
        endcase
        return {led, sc, wl, wr};
    endfunction

    task automatic step(input bit s, input bit l, input bit r, input bit rn);
        btn_start = s; btn_l = l; btn_r = r; rst_n = rn;
        @(posedge clk);
        model_clock(rn, s, l, r);
        #1;
    endtask

    task automatic start_game();
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (CNT) step(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        btn_l = 1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, (i < 3) ? 1'b0 : 1'b1);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL reset[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
        end
        checks++;
        if (led_control !== 2'd0 || score !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: got led=%0d score=%h want 0/00",
                     led_control, score);
        end
    endtask

    task automatic test_countdown();
        step(0, 0, 0, 1);
        for (int i = 0; i < CNT + 2; i++) begin
            step(i == 0, 0, 0, 1);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL countdown[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
        end
        checks++;
        if (led_control !== 2'd2 || score !== 8'h18) begin
            errors++;
            $display("FAIL countdown_end: got led=%0d score=%h want 2/18",
                     led_control, score);
        end
    endtask

    task automatic test_left_win();
        logic [7:0] want [3];
        want[0] = 8'h30; want[1] = 8'h60; want[2] = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL left_press[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
            if (i < 3) begin
                checks++;
                if (score !== want[i]) begin
                    errors++;
                    $display("FAIL left_score[%0d]: got %h want %h", i,
                             score, want[i]);
                end
            end
            step(0, 0, 0, 1);
        end
        checks++;
        if (win_l !== 1'b1 || led_control !== 2'd3) begin
            errors++;
            $display("FAIL left_win: got win_l=%0d led=%0d want 1/3",
                     win_l, led_control);
        end
        for (int i = 0; i < 4 * BLK; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL blink[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
        end
    endtask

    task automatic test_both_same_cycle();
        start_game();
        step(0, 1, 1, 1);
        checks++;
        if ({led_control, score, win_l, win_r} !== exp_vec() ||
            score !== 8'h18) begin
            errors++;
            $display("FAIL both_press: got %h want %h (score 18)",
                     {led_control, score, win_l, win_r}, exp_vec());
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_false_start();
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        checks++;
`ifdef TOW_FALSE_START_EN
        if (win_l !== 1'b1 || led_control !== 2'd3) begin
            errors++;
            $display("FAIL false_start: got win_l=%0d led=%0d want 1/3",
                     win_l, led_control);
        end
`else
        if (led_control !== 2'd1 || win_l !== 1'b0) begin
            errors++;
            $display("FAIL false_start: got win_l=%0d led=%0d want 0/1",
                     win_l, led_control);
        end
`endif
        for (int i = 0; i < CNT + 1; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL false_start_run[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_play();
        step(0, 0, 0, 0);
        start_game();
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 1);
            step(0, 0, 0, 1);
        end
        checks++;
        if (score !== 8'h60) begin
            errors++;
            $display("FAIL mid_play_pos5: got %h want 60", score);
        end
        step(0, 0, 0, 0);
        checks++;
        if (led_control !== 2'd0 || score !== 8'h00 ||
            {led_control, score, win_l, win_r} !== exp_vec()) begin
            errors++;
            $display("FAIL mid_play_reset: got led=%0d score=%h want 0/00",
                     led_control, score);
        end
        start_game();
        checks++;
        if (led_control !== 2'd2 || score !== 8'h18) begin
            errors++;
            $display("FAIL regame_center: got led=%0d score=%h want 2/18",
                     led_control, score);
        end
    endtask

    task automatic test_random();
        bit s, l, r, rn;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            s  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            step(s, l, r, rn);
            checks++;
            if ({led_control, score, win_l, win_r} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i,
                         {led_control, score, win_l, win_r}, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        m_mode = 0; m_cnt = 0; m_pos = 3; m_left = 0;
        m_ps = 1; m_pl = 1; m_pr = 1;
        test_reset();
        test_countdown();
        test_left_win();
        test_both_same_cycle();
        test_false_start();
        test_reset_mid_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
